// File: rtl/tcp_tx_scheduler.sv
// tcp_tx_scheduler
//   Shares one tcp_ip_transmitter between NUM_REQ frame requesters.
//   A round-robin arbiter picks a requester, latches its header fields onto
//   the transmitter inputs and pulses tx_en_o for EN_CYCLES cycles. It then
//   follows tx_busy_i until the frame ends, or aborts if busy never rises
//   within START_TIMEOUT cycles. Every frame end or abort is followed by an
//   enforced inter-frame gap of IFG_CYCLES cycles. A TCP sequence number is
//   kept per requester and advanced by the payload length on each
//   successful frame.
//
// Build option:
//   TX_PRIO0_EN - when defined, requester 0 has strict priority and the
//                 others share round-robin among themselves.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_i            level request per requester, held until done_o
//   dst_addr_i       per-requester IPv4 destination, slice k = [32k+31:32k]
//   ports_i          per-requester {src_port,dst_port}
//   len_i            per-requester payload byte count (16 bit slices)
//   tx_busy_i        transmitter busy
//   tx_en_o          transmitter enable
//   tx_dst_addr_o    transmitter destination address
//   tx_ports_o       transmitter {src_port,dst_port}
//   tx_data_count_o  zero-extended payload length of granted requester
//   tx_seq_o         transmitter TCP sequence number
//   gnt_o            one-hot grant, held for the whole frame
//   done_o           one-cycle pulse on successful frame end
//   err_o            one-cycle pulse on start timeout
//   idle_o           high only while idle
module tcp_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int EN_CYCLES     = 2,
  parameter int START_TIMEOUT = 16,
  parameter int IFG_CYCLES    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  dst_addr_i,
  input  logic [32*NUM_REQ-1:0]  ports_i,
  input  logic [16*NUM_REQ-1:0]  len_i,
  input  logic                   tx_busy_i,
  output logic                   tx_en_o,
  output logic [31:0]            tx_dst_addr_o,
  output logic [31:0]            tx_ports_o,
  output logic [31:0]            tx_data_count_o,
  output logic [31:0]            tx_seq_o,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic                   idle_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_gntIdx;
  logic [IW-1:0]      w_winIdx;
  logic [IW-1:0]      w_nextPtr;
  logic [IW-1:0]      w_scanIdx;
  logic [IW:0]        w_scanSum;
  logic               w_winFound;

  logic [CW-1:0]      r_enCnt;
  logic [CW-1:0]      r_toCnt;
  logic [CW-1:0]      r_gapCnt;
  logic               r_busySeen;

  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;
  logic [31:0]        r_dst;
  logic [31:0]        r_ports;
  logic [31:0]        r_len;
  logic [31:0]        r_seqOut;
  logic [31:0]        r_seq [NUM_REQ];

  logic               w_grant;
  logic               w_frameDone;
  logic               w_abort;

  // Round-robin search: walk the request vector starting at the pointer and
  // wrapping at NUM_REQ; the first set bit wins. With the priority option,
  // requester 0 is removed from the rotation and overrides any other winner.
  always_comb begin
    w_winFound = 1'b0;
    w_winIdx   = '0;
    w_scanSum  = '0;
    w_scanIdx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scanSum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_scanSum >= (IW+1)'(NUM_REQ)) begin
        w_scanSum = w_scanSum - (IW+1)'(NUM_REQ);
      end
      w_scanIdx = w_scanSum[IW-1:0];
`ifdef TX_PRIO0_EN
      if (!w_winFound && (w_scanIdx != '0) && req_i[w_scanIdx]) begin
`else
      if (!w_winFound && req_i[w_scanIdx]) begin
`endif
        w_winFound = 1'b1;
        w_winIdx   = w_scanIdx;
      end
    end
`ifdef TX_PRIO0_EN
    if (req_i[0]) begin
      w_winFound = 1'b1;
      w_winIdx   = '0;
    end
`endif
  end

  // Pointer value to use once the current frame finishes or aborts: the slot
  // just after the granted requester. With the priority option the pointer
  // skips slot 0 and is left alone when requester 0 was the one served.
  always_comb begin
    w_nextPtr = r_ptr;
`ifdef TX_PRIO0_EN
    if (r_gntIdx != '0) begin
      w_nextPtr = (r_gntIdx == IW'(NUM_REQ-1)) ? IW'(1) : r_gntIdx + IW'(1);
    end
`else
    w_nextPtr = (r_gntIdx == IW'(NUM_REQ-1)) ? '0 : r_gntIdx + IW'(1);
`endif
  end

  // Frame sequencing. A busy that was already seen during the enable pulse
  // sends us straight to WAIT_DONE; once there, a low busy is its falling
  // edge because busy has been observed high earlier in this frame.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_frameDone = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_i) w_nextState = S_ARB;
      end
      S_ARB: begin
        if (w_winFound) begin
          w_nextState = S_START;
          w_grant     = 1'b1;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      S_START: begin
        if (r_enCnt == CW'(EN_CYCLES-1)) begin
          w_nextState = (r_busySeen || tx_busy_i) ? S_WAIT_DONE : S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          w_nextState = S_WAIT_DONE;
        end else if (r_toCnt >= CW'(START_TIMEOUT-1)) begin
          w_nextState = S_GAP;
          w_abort     = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          w_nextState = S_GAP;
          w_frameDone = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gapCnt == CW'(IFG_CYCLES-1)) begin
          w_nextState = (|req_i) ? S_ARB : S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Datapath: counters, latched header fields, grant/pulse registers and the
  // per-requester sequence numbers. The timeout counter is cleared in ARB so
  // it reads 0 on the first enable cycle; done/err pulses are registered so
  // they appear in the same cycle the grant drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gntIdx   <= '0;
      r_enCnt    <= '0;
      r_toCnt    <= '0;
      r_gapCnt   <= '0;
      r_busySeen <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_dst      <= '0;
      r_ports    <= '0;
      r_len      <= '0;
      r_seqOut   <= '0;
      for (int k = 0; k < NUM_REQ; k++) r_seq[k] <= '0;
    end else begin
      r_done   <= '0;
      r_err    <= '0;
      r_enCnt  <= (r_state == S_START) ? r_enCnt + CW'(1) : '0;
      r_gapCnt <= (r_state == S_GAP) ? r_gapCnt + CW'(1) : '0;
      if (r_state == S_ARB) begin
        r_toCnt    <= '0;
        r_busySeen <= 1'b0;
      end else begin
        if (r_toCnt != '1) r_toCnt <= r_toCnt + CW'(1);
        if ((r_state == S_START) && tx_busy_i) r_busySeen <= 1'b1;
      end
      if (w_grant) begin
        r_gntIdx <= w_winIdx;
        r_gnt    <= NUM_REQ'(1) << w_winIdx;
        r_dst    <= dst_addr_i[32*w_winIdx +: 32];
        r_ports  <= ports_i[32*w_winIdx +: 32];
        r_len    <= {16'b0, len_i[16*w_winIdx +: 16]};
        r_seqOut <= r_seq[w_winIdx];
      end
      if (w_frameDone) begin
        r_done          <= r_gnt;
        r_gnt           <= '0;
        r_seq[r_gntIdx] <= r_seq[r_gntIdx] + r_len;
        r_ptr           <= w_nextPtr;
      end
      if (w_abort) begin
        r_err <= r_gnt;
        r_gnt <= '0;
        r_ptr <= w_nextPtr;
      end
    end
  end

  assign tx_en_o         = (r_state == S_START);
  assign idle_o          = (r_state == S_IDLE);
  assign gnt_o           = r_gnt;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign tx_dst_addr_o   = r_dst;
  assign tx_ports_o      = r_ports;
  assign tx_data_count_o = r_len;
  assign tx_seq_o        = r_seqOut;

endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// tb_tcp_tx_scheduler
//   Directed bench for tcp_tx_scheduler with default parameters
//   (NUM_REQ=4, EN_CYCLES=2, START_TIMEOUT=16, IFG_CYCLES=12). Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_tcp_tx_scheduler;

  localparam int NUM_REQ = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] dstBus;
  logic [127:0] portsBus;
  logic [63:0]  lenBus;
  logic         busy;

  logic         txEn;
  logic [31:0]  txDst;
  logic [31:0]  txPorts;
  logic [31:0]  txCount;
  logic [31:0]  txSeq;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         idle;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] dstTab   [4];
  logic [31:0] portsTab [4];
  int          rrOrder  [5];
  logic [31:0] rrSeq    [5];

  tcp_tx_scheduler #(
    .NUM_REQ(NUM_REQ),
    .EN_CYCLES(2),
    .START_TIMEOUT(16),
    .IFG_CYCLES(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .dst_addr_i(dstBus),
    .ports_i(portsBus),
    .len_i(lenBus),
    .tx_busy_i(busy),
    .tx_en_o(txEn),
    .tx_dst_addr_o(txDst),
    .tx_ports_o(txPorts),
    .tx_data_count_o(txCount),
    .tx_seq_o(txSeq),
    .gnt_o(gnt),
    .done_o(done),
    .err_o(err),
    .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Sets the request vector and gives every requester the same length.
  task automatic applyStimulus(input logic [3:0] reqV, input logic [15:0] lenV);
    req = reqV;
    for (int k = 0; k < NUM_REQ; k++) begin
      lenBus[16*k +: 16]   = lenV;
      dstBus[32*k +: 32]   = dstTab[k];
      portsBus[32*k +: 32] = portsTab[k];
    end
  endtask

  // Entered on the first enable cycle. Checks the latched header, the two
  // cycle enable, then models busy for busyCycles and checks the done pulse.
  // Returns on the first gap cycle.
  task automatic runFrame(input int k, input logic [31:0] expSeq,
                          input logic [31:0] expLen, input int busyCycles);
    logic [31:0] expGnt;
    expGnt = 32'(1) << k;
    checkOutput($sformatf("r%0d_en_rise", k), 32'(txEn), 32'h1);
    checkOutput($sformatf("r%0d_gnt", k), 32'(gnt), expGnt);
    checkOutput($sformatf("r%0d_seq", k), txSeq, expSeq);
    checkOutput($sformatf("r%0d_len", k), txCount, expLen);
    checkOutput($sformatf("r%0d_dst", k), txDst, dstTab[k]);
    checkOutput($sformatf("r%0d_ports", k), txPorts, portsTab[k]);
    @(negedge clk);
    checkOutput($sformatf("r%0d_en_hold", k), 32'(txEn), 32'h1);
    busy = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("r%0d_en_drop", k), 32'(txEn), 32'h0);
    checkOutput($sformatf("r%0d_gnt_hold", k), 32'(gnt), expGnt);
    repeat (busyCycles) @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("r%0d_done", k), 32'(done), expGnt);
    checkOutput($sformatf("r%0d_gnt_clear", k), 32'(gnt), 32'h0);
    checkOutput($sformatf("r%0d_no_err", k), 32'(err), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      dstTab[k]   = 32'hC0A8_0100 + 32'(k);
      portsTab[k] = {16'(1000 + k), 16'd80};
    end
`ifdef TX_PRIO0_EN
    rrOrder = '{0, 0, 0, 0, 0};
    rrSeq   = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
`else
    rrOrder = '{0, 1, 2, 3, 0};
    rrSeq   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
`endif

    // Reset state
    rst  = 1'b1;
    busy = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    checkOutput("rst_en", 32'(txEn), 32'h0);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_seq", txSeq, 32'h0);
    checkOutput("rst_dst", txDst, 32'h0);
    rst = 1'b0;

    // Single requester, len 0x40, busy held for 100 cycles
    applyStimulus(4'b0001, 16'h0040);
    @(negedge clk);
    checkOutput("lat_arb_en", 32'(txEn), 32'h0);
    checkOutput("lat_arb_idle", 32'(idle), 32'h0);
    @(negedge clk);
    runFrame(0, 32'h0, 32'h40, 100);
    applyStimulus(4'b0000, 16'h0040);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'h0);
    repeat (10) @(negedge clk);
    checkOutput("gap_last_cycle", 32'(idle), 32'h0);
    @(negedge clk);
    checkOutput("gap_to_idle", 32'(idle), 32'h1);

    // Second frame carries the advanced sequence number
    applyStimulus(4'b0001, 16'h0040);
    @(negedge clk);
    @(negedge clk);
    runFrame(0, 32'h40, 32'h40, 3);
    applyStimulus(4'b0000, 16'h0040);
    dstBus[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("dst_held", txDst, dstTab[0]);
    repeat (11) @(negedge clk);
    checkOutput("idle_after_f2", 32'(idle), 32'h1);

    // Start timeout: busy never rises
    applyStimulus(4'b0010, 16'h0040);
    @(negedge clk);
    @(negedge clk);
    checkOutput("to_en_rise", 32'(txEn), 32'h1);
    checkOutput("to_gnt", 32'(gnt), 32'h2);
    repeat (15) @(negedge clk);
    checkOutput("to_err_early", 32'(err), 32'h0);
    checkOutput("to_gnt_hold", 32'(gnt), 32'h2);
    @(negedge clk);
    checkOutput("to_err", 32'(err), 32'h2);
    checkOutput("to_gnt_clear", 32'(gnt), 32'h0);
    checkOutput("to_no_done", 32'(done), 32'h0);
    @(negedge clk);
    checkOutput("to_err_pulse", 32'(err), 32'h0);
    repeat (11) @(negedge clk);
    checkOutput("to_gap_en", 32'(txEn), 32'h0);
    @(negedge clk);
    runFrame(1, 32'h0, 32'h40, 4);

    // Reset while waiting for the frame to finish
    applyStimulus(4'b0100, 16'h0040);
    repeat (13) @(negedge clk);
    checkOutput("mid_en_rise", 32'(txEn), 32'h1);
    checkOutput("mid_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    checkOutput("mid_wait_en", 32'(txEn), 32'h0);
    checkOutput("mid_wait_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_gnt", 32'(gnt), 32'h0);
    checkOutput("mid_rst_en", 32'(txEn), 32'h0);
    checkOutput("mid_rst_idle", 32'(idle), 32'h1);
    checkOutput("mid_rst_done", 32'(done), 32'h0);
    checkOutput("mid_rst_err", 32'(err), 32'h0);
    checkOutput("mid_rst_dst", txDst, 32'h0);
    rst  = 1'b0;
    busy = 1'b0;
    applyStimulus(4'b0000, 16'h0001);
    @(negedge clk);
    checkOutput("post_rst_done", 32'(done), 32'h0);
    checkOutput("post_rst_idle", 32'(idle), 32'h1);

    // All four requesting, len 1, rotation from a fresh pointer
    applyStimulus(4'b1111, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      if (f > 0) begin
        repeat (12) @(negedge clk);
        checkOutput($sformatf("rr%0d_gap_en", f), 32'(txEn), 32'h0);
        @(negedge clk);
      end
      runFrame(rrOrder[f], rrSeq[f], 32'h1, 2);
    end
    applyStimulus(4'b0000, 16'h0001);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/tcp_tx_scheduler.md
Name: tcp_tx_scheduler

Overview:
Shares one tcp_ip_transmitter between NUM_REQ frame requesters. Arbitrates round-robin and muxes the winner's per-frame header fields onto the transmitter inputs. Pulses the transmitter enable, then tracks its busy handshake to completion. Keeps a per-requester TCP sequence number and enforces a minimum inter-frame gap.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
EN_CYCLES, 2, cycles tx_en_o is held high per frame (>=1)
START_TIMEOUT, 16, max cycles from tx_en_o rise to tx_busy_i rise before abort
IFG_CYCLES, 12, idle cycles enforced after every frame end or abort (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_i  in  NUM_REQ  level request per requester; must stay high until done_o
dst_addr_i  in  32*NUM_REQ  per-requester IPv4 destination, slice k = [32k+31:32k]
ports_i  in  32*NUM_REQ  per-requester {src_port,dst_port}
len_i  in  16*NUM_REQ  per-requester payload byte count
tx_busy_i  in  1  transmitter busy
tx_en_o  out  1  transmitter enable
tx_dst_addr_o  out  32  to transmitter Dst_addr
tx_ports_o  out  32  to transmitter SrcPort_DstPort
tx_data_count_o  out  32  zero-extended len of granted requester
tx_seq_o  out  32  to transmitter SequenceNum
gnt_o  out  NUM_REQ  one-hot grant, held from ARB exit until frame end or abort
done_o  out  NUM_REQ  one-cycle pulse on successful frame end
err_o  out  NUM_REQ  one-cycle pulse on start timeout
idle_o  out  1  high only in IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. tx_en_o, gnt_o, done_o, err_o = 0. All tx_* data outputs = 0. idle_o = 1. All sequence counters = 0. Round-robin pointer = 0. rst mid-frame aborts immediately with no done_o or err_o pulse.
- IDLE: if any req_i bit is set, go to ARB next cycle.
- ARB (1 cycle): pick the first set req_i bit scanning from pointer upward, wrapping at NUM_REQ. Set gnt_o. Register the winner's dst/ports/len and seq[k] onto the tx_* outputs. Go to START. If req_i has dropped to 0, return to IDLE.
- tx_* data outputs are stable from ARB exit until the next ARB. req_i data changes after the grant are ignored.
- START: tx_en_o=1 for exactly EN_CYCLES cycles. Timeout counter starts at the first tx_en_o cycle.
- If tx_busy_i is seen high in START, go to WAIT_DONE once the EN_CYCLES count completes.
- Otherwise go to WAIT_BUSY.
- WAIT_BUSY: tx_busy_i=1 -> WAIT_DONE. Timeout count reaching START_TIMEOUT -> abort: err_o[k] pulse, gnt_o cleared, seq unchanged, go to GAP.
- WAIT_DONE: on tx_busy_i falling (registered 1->0):
  - done_o[k] pulse, gnt_o cleared.
  - seq[k] <= seq[k] + len[k], modulo 2^32 (wraps).
  - pointer <= k+1 mod NUM_REQ.
  - Go to GAP.
- GAP: count IFG_CYCLES cycles, then go to IDLE, or directly to ARB if any req_i is set.
- Latency: req_i rise in IDLE -> tx_en_o high after 2 clk.
- Minimum frame spacing: tx_busy_i fall -> next tx_en_o rise = IFG_CYCLES+2 clk.
- No starvation: a continuously requesting requester is granted within NUM_REQ frames.
- Pointer also advances past k on abort.

Optional Feature:
TX_PRIO0_EN
- Defined: requester 0 has strict priority. In ARB, req_i[0]=1 always wins, regardless of pointer. Remaining requesters use round-robin among themselves. Pointer never advances to 0.
- Undefined: pure round-robin across all NUM_REQ, as above.

Test Plan:
- Single requester: rst, then req_i=4'b0001, len=0x0040 -> tx_en_o high 2 clk starting 2 clk after req; model busy 100 clk -> done_o[0] pulse; second frame tx_seq_o=0x40.
- Round-robin: req_i=4'b1111 held, all len=1 -> grant order 0,1,2,3,0. tx_busy_i fall to next tx_en_o rise = 14 clk.
- Timeout: req_i=4'b0010, tx_busy_i stuck 0 -> err_o[1] pulse 16 clk after tx_en_o rise. seq[1] stays 0. Next grant waits 12-cycle gap.
- Seq wrap: len=0xFFFF, after 65537 frames (or preload via forced counter) seq wraps 0xFFFFFFFF+len -> low bits correct, no overflow flag.
- Reset mid-frame: assert rst in WAIT_DONE -> next clk gnt_o=0, tx_en_o=0, idle_o=1, no done_o/err_o.
- With TX_PRIO0_EN: req_i=4'b1111 held -> requester 0 granted every frame. Without the macro: rotation 0,1,2,3.
